mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Synthesizable, parametrised self-check monitor for the RV32I core data-memory write port.
//  Watches MemWrite/DataAdr/WriteData and compares each store against an ordered table of expected stores.
//  Flags PASS when the last entry matches; FAIL on an unexpected store or a timeout.
//  Sits beside RV32I_TOP in benches and FPGA builds; replaces hard-coded address/data checks.
// PARAMETERS
//  ADDR_W      32    width of monitored address bus
//  DATA_W      32    width of monitored write-data bus
//  NUM_EXP     4     depth of expected-store table (>=1)
//  IGN_BASE    96    base of ignore window; stores here never fail
//  IGN_SIZE    4     ignore-window size in bytes; 0 disables the window
//  TIMEOUT_CYC 1000  cycles allowed from start to PASS; 0 disables timeout
// PORTS
//  clk        in   1                clock; all state updates on rising edge
//  reset      in   1                asynchronous, active-low reset
//  start      in   1                pulse: arm checker, clear index/timer/capture
//  cfg_we     in   1                write one table entry
//  cfg_idx    in   $clog2(NUM_EXP)  table entry index
//  cfg_addr   in   ADDR_W           expected store address
//  cfg_data   in   DATA_W           expected store data
//  cfg_count  in   $clog2(NUM_EXP)+1  number of valid entries; latched on start
//  MemWrite   in   1                monitored store strobe
//  DataAdr    in   ADDR_W           monitored store address
//  WriteData  in   DATA_W           monitored store data
//  armed      out  1                checker is in ARMED state
//  done       out  1                PASS or FAIL reached; sticky until start/reset
//  pass       out  1                valid when done=1
//  fail_code  out  2                0 none, 1 wrong addr, 2 wrong data, 3 timeout
//  fail_addr  out  ADDR_W           DataAdr captured at the failing store (0 on timeout)
//  fail_data  out  DATA_W           WriteData captured at the failing store (0 on timeout)
//  match_cnt  out  $clog2(NUM_EXP)+1  number of entries matched so far
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; all outputs 0; table contents cleared to 0.
//  - FSM states: IDLE, ARMED, PASS, FAIL.
//    Any state + start -> ARMED; idx, timer, match_cnt and captures cleared.
//    IDLE: wait for start.
//  - cfg_we is honoured only when state != ARMED; it is ignored while ARMED.
//  - Store sampling in ARMED: on a rising edge with MemWrite=1; one-cycle decision latency.
//    The store in the same cycle as start is not checked.
//  - Store decision, in priority order:
//    1. DataAdr==exp_addr[idx] and WriteData==exp_data[idx]: match; idx++ and match_cnt++.
//       If idx == count-1: PASS.
//    2. DataAdr inside [IGN_BASE, IGN_BASE+IGN_SIZE): ignored; no state change.
//    3. DataAdr==exp_addr[idx] with wrong data: FAIL, code 2.
//    4. Otherwise: FAIL, code 1.
//    On FAIL, capture DataAdr and WriteData.
//  - Ignore-window bound is computed in ADDR_W+1 bits, so it does not wrap.
//  - Timer: counts ARMED cycles, saturating.
//    If TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 with no PASS in that cycle: FAIL, code 3.
//    A match on the final cycle takes priority over timeout.
//  - cfg_count==0 at start: ARMED -> PASS on the next edge.
//  - cfg_count>NUM_EXP: clamped to NUM_EXP.
//  - PASS/FAIL: further stores ignored; outputs held until start or reset.
//  - Reset mid-ARMED: immediate return to IDLE; table cleared, so it must be reloaded.
// CONFIGURATION
//  - MWC_BYTE_MASK_EN defined:
//    Adds input cfg_mask[DATA_W-1:0] and a per-entry mask in the table.
//    Data compare becomes (WriteData & mask)==(exp_data & mask); mask resets to all-ones.
//  - Not defined: no cfg_mask port; compare is full-width equality.
// STRUCTURE
//  - Package mwc_pkg:
//    state enum (IDLE/ARMED/PASS/FAIL);
//    fail-code constants FC_NONE/FC_ADDR/FC_DATA/FC_TIMEOUT.
//  - Sub-module mwc_exp_table:
//    NUM_EXP-entry register file (addr, data, optional mask);
//    sync write, async read at idx; async active-low clear.
// TESTING
//  1. Load {100:25}, count=1, ignore 96..99.
//     Stores (96,7) then (100,25) -> pass=1, match_cnt=1, done one edge after the store.
//  2. Same config, store (104,25) -> FAIL, fail_code=1, fail_addr=104, fail_data=25.
//  3. Load {100:25, 104:9}, count=2.
//     Stores (100,25),(104,8) -> fail_code=2, match_cnt=1.
//  4. TIMEOUT_CYC=20, no stores -> fail_code=3 exactly 20 cycles after start.
//     Store matching on cycle 19 -> PASS instead.
//  5. Assert reset mid-ARMED after 1 match -> all outputs 0 asynchronously.
//     Reload table, start, replay -> PASS.
//  6. MWC_BYTE_MASK_EN, mask 0x000000FF, expect {100:0x25}.
//     Store (100,0xAB25) -> PASS; without the macro, the same store -> fail_code=2.

Source files
------------

// File: rtl/mwc_pkg.sv
// mwc_pkg: checker state encoding and fail codes shared by mem_write_checker and its bench.
package mwc_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_e;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ADDR    = 2'd1;
  localparam logic [1:0] FC_DATA    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;
endpackage

// File: rtl/mwc_exp_table.sv
// mwc_exp_table: expected-store register file, sync write, async read, async active-low clear.
// Holds a per-entry data mask (reset to all-ones) when MWC_BYTE_MASK_EN is defined.
module mwc_exp_table #(
  parameter int NUM_EXP = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IW      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MWC_BYTE_MASK_EN
  input  logic [DATA_W-1:0] wmask,
  output logic [DATA_W-1:0] rmask,
`endif
  input  logic [IW-1:0]     ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [ADDR_W-1:0] addr_q [NUM_EXP];
  logic [DATA_W-1:0] data_q [NUM_EXP];
`ifdef MWC_BYTE_MASK_EN
  logic [DATA_W-1:0] mask_q [NUM_EXP];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_EXP; i++) mask_q[i] <= '1;
    else if (we) mask_q[widx] <= wmask;
  assign rmask = mask_q[ridx];
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we) begin
      addr_q[widx] <= waddr;
      data_q[widx] <= wdata;
    end
  assign raddr = addr_q[ridx];
  assign rdata = data_q[ridx];
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks data-memory stores against an ordered table of expected stores.
// Define MWC_BYTE_MASK_EN to add cfg_mask and a per-entry masked data compare.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int IGN_BASE    = 96,
  parameter int IGN_SIZE    = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IW = NUM_EXP > 1 ? $clog2(NUM_EXP) : 1,
  localparam int CW = $clog2(NUM_EXP) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
`ifdef MWC_BYTE_MASK_EN
  input  logic [DATA_W-1:0] cfg_mask,
`endif
  input  logic [CW-1:0]     cfg_count,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              armed,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CW-1:0]     match_cnt
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W:0] IGN_LO = (ADDR_W+1)'(IGN_BASE);
  localparam logic [ADDR_W:0] IGN_HI = (ADDR_W+1)'(IGN_BASE) + (ADDR_W+1)'(IGN_SIZE);
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              addr_ok, data_ok, ign, hit, last, tmo;
`ifdef MWC_BYTE_MASK_EN
  logic [DATA_W-1:0] exp_mask;
`endif
  // match_cnt doubles as the table read index
  mwc_exp_table #(.NUM_EXP(NUM_EXP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IW(IW)) u_tab (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we && state_q != ARMED),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
`ifdef MWC_BYTE_MASK_EN
    .wmask (cfg_mask),
    .rmask (exp_mask),
`endif
    .ridx  (match_cnt[IW-1:0]),
    .raddr (exp_addr),
    .rdata (exp_data)
  );
  assign addr_ok = DataAdr == exp_addr;
`ifdef MWC_BYTE_MASK_EN
  assign data_ok = (WriteData & exp_mask) == (exp_data & exp_mask);
`else
  assign data_ok = WriteData == exp_data;
`endif
  assign ign  = IGN_SIZE != 0 && {1'b0, DataAdr} >= IGN_LO && {1'b0, DataAdr} < IGN_HI;
  assign hit  = MemWrite && cnt_q != '0 && addr_ok && data_ok;
  assign last = match_cnt + CW'(1) == cnt_q;
  assign tmo  = TIMEOUT_CYC != 0 && timer_q == T_LAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      armed     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
    end else if (start) begin
      state_q   <= ARMED;
      cnt_q     <= cfg_count > CW'(NUM_EXP) ? CW'(NUM_EXP) : cfg_count;
      timer_q   <= '0;
      armed     <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
    end else if (state_q == ARMED) begin
      timer_q <= &timer_q ? timer_q : timer_q + TW'(1);
      if (hit) match_cnt <= match_cnt + CW'(1);
      if (cnt_q == '0 || (hit && last)) begin
        state_q <= PASS;
        armed   <= 1'b0;
        done    <= 1'b1;
        pass    <= 1'b1;
      end else if (MemWrite && !hit && !ign) begin
        state_q   <= FAIL;
        armed     <= 1'b0;
        done      <= 1'b1;
        fail_code <= addr_ok ? FC_DATA : FC_ADDR;
        fail_addr <= DataAdr;
        fail_data <= WriteData;
      end else if (tmo) begin
        state_q   <= FAIL;
        armed     <= 1'b0;
        done      <= 1'b1;
        fail_code <= FC_TIMEOUT;
      end
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: scenario tasks with a result scoreboard for mem_write_checker.
module tb_mem_write_checker;
  logic        clk = 0, reset = 0, start = 0, cfg_we = 0, MemWrite = 0;
  logic [1:0]  cfg_idx = 0;
  logic [2:0]  cfg_count = 0;
  logic [31:0] cfg_addr = 0, cfg_data = 0, DataAdr = 0, WriteData = 0;
`ifdef MWC_BYTE_MASK_EN
  logic [31:0] cfg_mask = '1;
`endif
  logic        armed, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  match_cnt;
  typedef struct packed {
    logic        d;
    logic        p;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  m;
  } res_t;
  res_t sb[$];
  res_t got;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(4), .IGN_BASE(96), .IGN_SIZE(4), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef MWC_BYTE_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cfg_count(cfg_count), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .armed(armed), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_data(fail_data), .match_cnt(match_cnt)
  );

  assign got = {done, pass, fail_code, fail_addr, fail_data, match_cnt};

  function automatic res_t mk(input logic p, input logic [1:0] c, input logic [31:0] a,
                              input logic [31:0] w, input logic [2:0] m);
    return {1'b1, p, c, a, w, m};
  endfunction

  task automatic load(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_idx = i; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic arm(input logic [2:0] c);
    start = 1; cfg_count = c;
    @(negedge clk);
    start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 0;
  endtask

  task automatic wait_done(input string n, input int lim);
    for (int i = 0; i < lim && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_timeout: done=%b after %0d cycles, need 1", n, done, lim); end
  endtask

  task automatic test_reset;
    res_t e;
    #12;
    checks++;
    if (got !== '0 || armed !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %h armed %b, need all 0", got, armed); end
    @(negedge clk); reset = 1;
    arm(1); sb.push_back(mk(1, 0, 0, 0, 1));
    store(0, 0); wait_done("table_cleared", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL table_cleared: got %h need %h", got, e); end
  endtask

  task automatic test_ignore_pass;
    res_t e;
    load(0, 100, 25); arm(1); sb.push_back(mk(1, 0, 0, 0, 1));
    store(96, 7); checks++;
    if (done !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL ignore_window: done=%b armed=%b need 0/1", done, armed); end
    store(100, 25); checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_latency: done=%b one edge after store, need 1", done); end
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL ignore_pass: got %h need %h", got, e); end
  endtask

  task automatic test_wrong_addr;
    res_t e;
    arm(1); sb.push_back(mk(0, 1, 104, 25, 0));
    store(104, 25); wait_done("wrong_addr", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL wrong_addr: got %h need %h", got, e); end
  endtask

  task automatic test_wrong_data;
    res_t e;
    load(1, 104, 9); arm(2); sb.push_back(mk(0, 2, 104, 8, 1));
    store(100, 25); store(104, 8); wait_done("wrong_data", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL wrong_data: got %h need %h", got, e); end
  endtask

  task automatic test_timeout;
    res_t e;
    int n = 0;
    arm(2); sb.push_back(mk(0, 3, 0, 0, 0));
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 20) begin errors++; $display("FAIL timeout_cycles: done after %0d cycles, need 20", n); end
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL timeout_code: got %h need %h", got, e); end
    arm(1); sb.push_back(mk(1, 0, 0, 0, 1));
    repeat (19) @(negedge clk);
    store(100, 25);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL match_on_last_cycle: got %h need %h", got, e); end
  endtask

  task automatic test_count_zero;
    res_t e;
    arm(0); checks++;
    if (done !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL count_zero_armed: done=%b armed=%b need 0/1", done, armed); end
    @(negedge clk); sb.push_back(mk(1, 0, 0, 0, 0));
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL count_zero_pass: got %h need %h", got, e); end
  endtask

  task automatic test_cfg_locked;
    res_t e;
    arm(1); load(0, 200, 1); sb.push_back(mk(1, 0, 0, 0, 1));
    store(100, 25); wait_done("cfg_locked", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL cfg_locked: got %h need %h", got, e); end
  endtask

  task automatic test_back_to_back;
    res_t e;
    for (int i = 0; i < 4; i++) load(2'(i), 32'(200 + 4 * i), 32'(i + 1));
    arm(7); sb.push_back(mk(1, 0, 0, 0, 4));
    for (int i = 0; i < 4; i++) store(32'(200 + 4 * i), 32'(i + 1));
    wait_done("back_to_back", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL back_to_back_clamp: got %h need %h", got, e); end
  endtask

  task automatic test_reset_mid;
    res_t e;
    load(0, 100, 25); load(1, 104, 9); arm(2);
    store(100, 25); checks++;
    if (match_cnt !== 3'd1 || armed !== 1'b1) begin errors++; $display("FAIL mid_match: match_cnt=%0d armed=%b need 1/1", match_cnt, armed); end
    @(posedge clk); #2 reset = 0; #1;
    checks++;
    if (got !== '0 || armed !== 1'b0) begin errors++; $display("FAIL async_reset: got %h armed %b, need all 0", got, armed); end
    @(negedge clk); reset = 1;
    load(0, 100, 25); load(1, 104, 9); arm(2); sb.push_back(mk(1, 0, 0, 0, 2));
    store(100, 25); store(104, 9); wait_done("replay", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL replay_pass: got %h need %h", got, e); end
  endtask

  task automatic test_mask;
    res_t e;
`ifdef MWC_BYTE_MASK_EN
    cfg_mask = 32'hFF;
`endif
    load(0, 100, 32'h25);
`ifdef MWC_BYTE_MASK_EN
    cfg_mask = '1;
    sb.push_back(mk(1, 0, 0, 0, 1));
`else
    sb.push_back(mk(0, 2, 100, 32'hAB25, 0));
`endif
    arm(1); store(100, 32'hAB25); wait_done("mask", 2);
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mask_compare: got %h need %h", got, e); end
  endtask

  initial begin
    test_reset;
    test_ignore_pass;
    test_wrong_addr;
    test_wrong_data;
    test_timeout;
    test_count_zero;
    test_cfg_locked;
    test_back_to_back;
    test_reset_mid;
    test_mask;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
